// File: rtl/cluster_sparse_compressor.sv
// Sparse cluster compressor: collects a window of dense beats, then emits a
// non-zero bitmask followed by the non-zero clusters packed into transfer blocks.
module cluster_sparse_compressor #(
    parameter int TRANSFER_SIZE           = 4,
    parameter int CLUSTER_BITWIDTH        = 8,
    parameter int COMPRESSION_WINDOW_SIZE = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [TRANSFER_SIZE*CLUSTER_BITWIDTH-1:0] idata,
    input  logic                                      ivalid,
    input  logic                                      ilast,
    output logic                                      iready,
    output logic [TRANSFER_SIZE*CLUSTER_BITWIDTH-1:0] odata,
    output logic                                      ovalid,
    input  logic                                      oready,
    output logic                                      oisMask,
    output logic                                      olast
);

    localparam int BEAT_WIDTH     = TRANSFER_SIZE * CLUSTER_BITWIDTH;
    localparam int BEATS          = COMPRESSION_WINDOW_SIZE / TRANSFER_SIZE;
    localparam int COUNT_WIDTH    = $clog2(COMPRESSION_WINDOW_SIZE) + 1;
    localparam int INDEX_WIDTH    = $clog2(COMPRESSION_WINDOW_SIZE);
    localparam int BEAT_CNT_WIDTH = $clog2(BEATS + 1);

    typedef enum logic [1:0] {COLLECT, EMIT_MASK, EMIT_DATA} stateType;

    stateType                            state, stateNext;
    logic [COMPRESSION_WINDOW_SIZE-1:0] mask, maskNext;
    logic [CLUSTER_BITWIDTH-1:0]         store     [COMPRESSION_WINDOW_SIZE];
    logic [CLUSTER_BITWIDTH-1:0]         storeNext [COMPRESSION_WINDOW_SIZE];
    logic [COUNT_WIDTH-1:0]              count, countNext;
    logic [BEAT_CNT_WIDTH-1:0]           beatCnt;
    logic [COUNT_WIDTH-1:0]              blockIdx;
    logic [COUNT_WIDTH-1:0]              slot;
    logic [TRANSFER_SIZE-1:0]            beatNonZero;
    logic [BEAT_WIDTH-1:0]               blockData;
    logic                                inFire, outFire, lastBeat, lastBlock;

    assign inFire    = ivalid && iready;
    assign outFire   = ovalid && oready;
    assign lastBeat  = (beatCnt == BEAT_CNT_WIDTH'(BEATS - 1)) || ilast;
    assign lastBlock = ((int'(blockIdx) + 1) * TRANSFER_SIZE) >= int'(count);

    // Append this beat's non-zero clusters behind those already stored.
    always_comb begin
        storeNext   = store;
        countNext   = count;
        beatNonZero = '0;
        for (int j = 0; j < TRANSFER_SIZE; j++) begin
            beatNonZero[j] = |idata[j*CLUSTER_BITWIDTH +: CLUSTER_BITWIDTH];
            if (beatNonZero[j]) begin
                storeNext[countNext[INDEX_WIDTH-1:0]] = idata[j*CLUSTER_BITWIDTH +: CLUSTER_BITWIDTH];
                countNext = countNext + COUNT_WIDTH'(1);
            end
        end
        maskNext = mask | (COMPRESSION_WINDOW_SIZE'(beatNonZero) << (int'(beatCnt) * TRANSFER_SIZE));
    end

    // Slots past the count read as zero, so stale store contents never leak out.
    always_comb begin
        blockData = '0;
        slot      = '0;
        for (int j = 0; j < TRANSFER_SIZE; j++) begin
            slot = blockIdx * COUNT_WIDTH'(TRANSFER_SIZE) + COUNT_WIDTH'(j);
            if (slot < count) begin
                blockData[j*CLUSTER_BITWIDTH +: CLUSTER_BITWIDTH] = store[slot[INDEX_WIDTH-1:0]];
            end
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        stateNext = state;
        iready    = 1'b0;
        ovalid    = 1'b0;
        oisMask   = 1'b0;
        olast     = 1'b0;
        odata     = '0;
        case (state)
            COLLECT: begin
                iready = 1'b1;
                if (ivalid && lastBeat) stateNext = EMIT_MASK;
            end
            EMIT_MASK: begin
                ovalid  = 1'b1;
                oisMask = 1'b1;
                olast   = (count == '0);
                odata   = BEAT_WIDTH'(mask);
                if (oready) stateNext = (count == '0) ? COLLECT : EMIT_DATA;
            end
            EMIT_DATA: begin
                ovalid = 1'b1;
                olast  = lastBlock;
                odata  = blockData;
                if (oready && lastBlock) stateNext = COLLECT;
            end
            default: stateNext = COLLECT;
        endcase
        if (reset) begin
            iready  = 1'b0;
            ovalid  = 1'b0;
            oisMask = 1'b0;
            olast   = 1'b0;
            odata   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= COLLECT;
            mask     <= '0;
            count    <= '0;
            beatCnt  <= '0;
            blockIdx <= '0;
        end else begin
            state <= stateNext;
            if (inFire) begin
                mask    <= maskNext;
                count   <= countNext;
                beatCnt <= beatCnt + BEAT_CNT_WIDTH'(1);
            end
            if (outFire && state == EMIT_DATA) blockIdx <= blockIdx + COUNT_WIDTH'(1);
            if (outFire && olast) begin
                mask     <= '0;
                count    <= '0;
                beatCnt  <= '0;
                blockIdx <= '0;
            end
        end
    end

    // NOTE: the cluster store is not reset; clearing the count is enough since reads past it return zero.
    always_ff @(posedge clock) begin
        if (inFire) store <= storeNext;
    end

endmodule

// File: tb/tb_cluster_sparse_compressor.sv
// Directed bench for cluster_sparse_compressor: drives windows of beats and
// checks every mask/block beat cycle by cycle against hand-computed values.
module tb_cluster_sparse_compressor;

    logic        clock;
    logic        reset;
    logic [31:0] idata;
    logic        ivalid;
    logic        ilast;
    logic        iready;
    logic [31:0] odata;
    logic        ovalid;
    logic        oready;
    logic        oisMask;
    logic        olast;

    int errorCount = 0;
    int checkCount = 0;

    logic [31:0] beats  [8];
    logic [31:0] blocks [8];

    cluster_sparse_compressor #(
        .TRANSFER_SIZE(4),
        .CLUSTER_BITWIDTH(8),
        .COMPRESSION_WINDOW_SIZE(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .idata(idata),
        .ivalid(ivalid),
        .ilast(ilast),
        .iready(iready),
        .odata(odata),
        .ovalid(ovalid),
        .oready(oready),
        .oisMask(oisMask),
        .olast(olast)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic clearVectors();
        for (int i = 0; i < 8; i++) begin
            beats[i]  = 32'h0;
            blocks[i] = 32'h0;
        end
    endtask

    task automatic setDense();
        for (int i = 0; i < 8; i++) begin
            beats[i]  = 32'h04030201 + 32'(i) * 32'h04040404;
            blocks[i] = beats[i];
        end
    endtask

    // Entered and left at posedge+1; outputs are sampled on the falling edge.
    task automatic runWindow(input string tag, input int nBeats, input logic useLast,
                             input logic [31:0] expMask, input int nBlocks,
                             input int stallIdx, input int stallCycles, input int resetIdx);
        for (int b = 0; b < nBeats; b++) begin
            idata  = beats[b];
            ivalid = 1'b1;
            ilast  = useLast && (b == nBeats - 1);
            @(negedge clock);
            check({tag, "_iready"}, 32'(iready), 32'd1);
            check({tag, "_novalid"}, 32'(ovalid), 32'd0);
            @(posedge clock); #1;
        end
        ivalid = 1'b0;
        ilast  = 1'b0;
        idata  = 32'h0;
        @(negedge clock);
        check({tag, "_mask_valid"}, 32'(ovalid), 32'd1);
        check({tag, "_mask_ismask"}, 32'(oisMask), 32'd1);
        check({tag, "_mask_data"}, odata, expMask);
        check({tag, "_mask_last"}, 32'(olast), 32'(nBlocks == 0));
        check({tag, "_mask_iready"}, 32'(iready), 32'd0);
        @(posedge clock); #1;
        for (int k = 0; k < nBlocks; k++) begin
            if (k == resetIdx) begin
                reset = 1'b1;
                @(negedge clock);
                check({tag, "_rst_ovalid"}, 32'(ovalid), 32'd0);
                check({tag, "_rst_iready"}, 32'(iready), 32'd0);
                @(posedge clock); #1;
                reset = 1'b0;
                @(negedge clock);
                check({tag, "_post_rst_ovalid"}, 32'(ovalid), 32'd0);
                check({tag, "_post_rst_iready"}, 32'(iready), 32'd1);
                @(posedge clock); #1;
                return;
            end
            if (k == stallIdx) begin
                oready = 1'b0;
                for (int s = 0; s < stallCycles; s++) begin
                    @(negedge clock);
                    check({tag, "_stall_valid"}, 32'(ovalid), 32'd1);
                    check({tag, "_stall_data"}, odata, blocks[k]);
                    check({tag, "_stall_last"}, 32'(olast), 32'(k == nBlocks - 1));
                    @(posedge clock); #1;
                end
                oready = 1'b1;
            end
            @(negedge clock);
            check({tag, "_blk_valid"}, 32'(ovalid), 32'd1);
            check({tag, "_blk_ismask"}, 32'(oisMask), 32'd0);
            check({tag, "_blk_data"}, odata, blocks[k]);
            check({tag, "_blk_last"}, 32'(olast), 32'(k == nBlocks - 1));
            @(posedge clock); #1;
        end
        @(negedge clock);
        check({tag, "_next_iready"}, 32'(iready), 32'd1);
        check({tag, "_idle_ovalid"}, 32'(ovalid), 32'd0);
        @(posedge clock); #1;
    endtask

    initial begin
        reset  = 1'b1;
        ivalid = 1'b0;
        ilast  = 1'b0;
        idata  = 32'h0;
        oready = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check("reset_iready", 32'(iready), 32'd0);
        check("reset_ovalid", 32'(ovalid), 32'd0);
        check("reset_odata", odata, 32'h0);
        check("reset_ismask", 32'(oisMask), 32'd0);
        check("reset_olast", 32'(olast), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("after_reset_iready", 32'(iready), 32'd1);
        check("after_reset_ovalid", 32'(ovalid), 32'd0);
        @(posedge clock); #1;

        setDense();
        runWindow("dense", 8, 1'b0, 32'hFFFFFFFF, 8, -1, 0, -1);

        // Clusters 0 (0x01) and 2 (0x03) of beat 0 are non-zero.
        clearVectors();
        beats[0]  = 32'h00030001;
        blocks[0] = 32'h00000301;
        runWindow("sparse", 8, 1'b0, 32'h00000005, 1, -1, 0, -1);
        runWindow("sparse_last8", 8, 1'b1, 32'h00000005, 1, -1, 0, -1);

        clearVectors();
        runWindow("zero", 8, 1'b0, 32'h00000000, 0, -1, 0, -1);

        // Beat 0 cluster 1 (0x05) -> bit 1; beat 1 clusters 0 (0x0B) and 3 (0x07) -> bits 4 and 7.
        clearVectors();
        beats[0]  = 32'h00000500;
        beats[1]  = 32'h0700000B;
        blocks[0] = 32'h00070B05;
        runWindow("short", 2, 1'b1, 32'h00000092, 1, -1, 0, -1);

        // Five non-zero clusters: the second block carries one cluster and three zero slots.
        clearVectors();
        beats[0]  = 32'h01020304;
        beats[3]  = 32'h00000900;
        blocks[0] = 32'h01020304;
        blocks[1] = 32'h00000009;
        runWindow("partial", 8, 1'b0, 32'h0000200F, 2, -1, 0, -1);

        setDense();
        runWindow("backpressure", 8, 1'b0, 32'hFFFFFFFF, 8, 2, 3, -1);

        setDense();
        runWindow("reset_emit", 8, 1'b0, 32'hFFFFFFFF, 8, -1, 0, 4);

        clearVectors();
        beats[0]  = 32'h00030001;
        blocks[0] = 32'h00000301;
        runWindow("sparse_after_reset", 8, 1'b0, 32'h00000005, 1, -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
